// File: rtl/button_press_decoder.sv
// Turns a debounced button level into one-cycle stopwatch command pulses
// (down, short, long, repeat) plus a held level; all outputs are registered.
module button_press_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic down_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic rpt_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit               RPT_EN    = (REPEAT_TICKS != 0);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             downNext;
  logic             shortNext;
  logic             longNext;
  logic             rptNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_REL;
      cnt         <= '0;
      down_pulse  <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      rpt_pulse   <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      down_pulse  <= downNext;
      short_pulse <= shortNext;
      long_pulse  <= longNext;
      rpt_pulse   <= rptNext;
    end
  end

  // Release is tested before any tick so it always beats a coincident threshold.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    downNext  = 1'b0;
    shortNext = 1'b0;
    longNext  = 1'b0;
    rptNext   = 1'b0;
    unique case (state)
      WAIT_REL: begin
        if (!btn) stateNext = IDLE;
      end
      IDLE: begin
        if (btn) begin
          stateNext = PRESSED;
          cntNext   = '0;
          downNext  = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn) begin
          stateNext = IDLE;
          shortNext = 1'b1;
        end else if (tick) begin
          if (cnt == LONG_LAST) begin
            stateNext = LONG;
            cntNext   = '0;
            longNext  = 1'b1;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
      end
      LONG: begin
        if (!btn) begin
          stateNext = IDLE;
        end else if (tick && RPT_EN) begin
          if (cnt == RPT_LAST) begin
            cntNext = '0;
            rptNext = 1'b1;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
      end
      default: stateNext = WAIT_REL;
    endcase
  end

  assign held = (state == PRESSED) || (state == LONG);

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench: stimulus pushes expected pulses (kind + edge number) into a
// scoreboard queue; a negedge monitor pops and compares each pulse it sees.
module tb_button_press_decoder;

  localparam int LONG_TICKS   = 4;
  localparam int REPEAT_TICKS = 2;
  localparam int CNT_W        = 8;

  localparam logic [3:0] K_DOWN  = 4'b1000;
  localparam logic [3:0] K_SHORT = 4'b0100;
  localparam logic [3:0] K_LONG  = 4'b0010;
  localparam logic [3:0] K_RPT   = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn;
  logic down_pulse;
  logic short_pulse;
  logic long_pulse;
  logic rpt_pulse;
  logic held;

  exp_t sbQueue[$];
  int   edgeIdx = 0;
  int   checks  = 0;
  int   errors  = 0;

  button_press_decoder #(
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn        (btn),
    .down_pulse (down_pulse),
    .short_pulse(short_pulse),
    .long_pulse (long_pulse),
    .rpt_pulse  (rpt_pulse),
    .held       (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeIdx <= edgeIdx + 1;

  // Every pulse the DUT shows must be the oldest scoreboard entry, on its edge.
  always @(negedge clk) begin
    logic [3:0] obs;
    exp_t       e;
    obs = {down_pulse, short_pulse, long_pulse, rpt_pulse};
    if (edgeIdx > 0 && obs !== 4'b0000) begin
      checks++;
      if (sbQueue.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got kind=%b at edge %0d, expected none", obs, edgeIdx);
      end else begin
        e = sbQueue.pop_front();
        if (e.kind !== obs || e.at != edgeIdx) begin
          errors++;
          $display("[TB] FAIL pulse: got kind=%b at edge %0d, expected kind=%b at edge %0d",
                   obs, edgeIdx, e.kind, e.at);
        end
      end
    end
  end

  task automatic applyStimulus(input logic b, input logic t, input logic r, input int n);
    repeat (n) begin
      btn  = b;
      tick = t;
      rst  = r;
      @(negedge clk);
    end
  endtask

  task automatic expectPulse(input logic [3:0] kind, input int delay);
    exp_t e;
    e.kind = kind;
    e.at   = edgeIdx + delay;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] expected);
    logic [4:0] actual;
    actual = {down_pulse, short_pulse, long_pulse, rpt_pulse, held};
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got {down,short,long,rpt,held}=%b, expected %b", name, actual, expected);
    end
  endtask

  initial begin
    btn  = 1'b1;
    tick = 1'b1;
    rst  = 1'b1;

    // Button held through reset: nothing until it is released.
    applyStimulus(1'b1, 1'b1, 1'b1, 2);
    checkOutput("reset_state", 5'b00000);
    applyStimulus(1'b1, 1'b1, 1'b0, 10);
    checkOutput("held_through_reset", 5'b00000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("wait_rel_to_idle", 5'b00000);
    expectPulse(K_DOWN, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("first_press_down", 5'b10001);
    expectPulse(K_SHORT, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("first_release_short", 5'b01000);

    // Short press of two cycles.
    expectPulse(K_DOWN, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("short_down", 5'b10001);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("short_held", 5'b00001);
    expectPulse(K_SHORT, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("short_release", 5'b01000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("short_idle", 5'b00000);

    // Nine-cycle hold: long then two repeats, silent release.
    expectPulse(K_DOWN, 1);
    expectPulse(K_LONG, 5);
    expectPulse(K_RPT, 7);
    expectPulse(K_RPT, 9);
    applyStimulus(1'b1, 1'b1, 1'b0, 9);
    checkOutput("long_second_rpt", 5'b00011);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("long_release_silent", 5'b00000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // Release on the same edge as the threshold tick.
    expectPulse(K_DOWN, 1);
    expectPulse(K_SHORT, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("race_before", 5'b00001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("race_release_wins", 5'b01000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // Sparse ticks: counter only advances on tick.
    expectPulse(K_DOWN, 1);
    expectPulse(K_LONG, 17);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, (i % 4) == 0, 1'b0, 1);
      if (i == 15) checkOutput("sparse_before_long", 5'b00001);
      if (i == 16) checkOutput("sparse_long", 5'b00101);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("sparse_release", 5'b00000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // Reset in the middle of a long hold.
    expectPulse(K_DOWN, 1);
    expectPulse(K_LONG, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    checkOutput("pre_reset_long", 5'b00001);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("mid_hold_reset", 5'b00000);
    applyStimulus(1'b1, 1'b1, 1'b0, 5);
    checkOutput("post_reset_still_held", 5'b00000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    expectPulse(K_DOWN, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("post_reset_press", 5'b10001);
    expectPulse(K_SHORT, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);

    // Button toggling every cycle.
    expectPulse(K_DOWN, 1);
    expectPulse(K_SHORT, 2);
    expectPulse(K_DOWN, 3);
    expectPulse(K_SHORT, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("toggle_down", 5'b10001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("toggle_short", 5'b01000);

    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending pulses, expected 0", sbQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
